// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: programmable video raster timing generator with frame-synchronous config apply
//   clk, rst (async, active-high), en (pixel clock enable)
//   cfg_we/cfg_addr/cfg_data : write one shadow timing register
//   cfg_commit / cfg_pending : request / flag for shadow -> active copy at the next frame end
//   pix_x, pix_y, blank, de, hsync, vsync, line_start, frame_start : registered raster outputs
module vga_timing_ctrl #(
   parameter int C = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         cfg_we,
   input  logic [2:0]   cfg_addr,
   input  logic [C-1:0] cfg_data,
   input  logic         cfg_commit,
   output logic         cfg_pending,
   output logic [C-1:0] pix_x,
   output logic [C-1:0] pix_y,
   output logic         blank,
   output logic         de,
   output logic         hsync,
   output logic         vsync,
   output logic         line_start,
   output logic         frame_start
);
   // h_blank_start, h_sync_start, h_sync_end, h_total, v_blank_start, v_sync_start, v_sync_end, v_total
   localparam logic [C-1:0] DEF [8] = '{C'(640), C'(656), C'(752), C'(800),
                                        C'(480), C'(490), C'(492), C'(525)};
   logic [C-1:0] a [8];
   logic [C-1:0] s [8];
   logic [C-1:0] hc, vc;
   logic [C:0]   hn, vn;
   logic         hw, vw, ap, hb, vb, hs, vs;
   // wrap compares run one bit wider so a total at the top of the range still wraps
   always_comb begin
      hn = {1'b0, hc} + (C+1)'(1);
      vn = {1'b0, vc} + (C+1)'(1);
      hw = hn >= {1'b0, a[3]};
      vw = vn >= {1'b0, a[7]};
      ap = en & hw & vw & cfg_pending;
      hb = hc >= a[0];
      vb = vc >= a[4];
      hs = (hc >= a[1]) && (hc < a[2]);
      vs = (vc >= a[5]) && (vc < a[6]);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hc          <= '0;
         vc          <= '0;
         cfg_pending <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         blank       <= 1'b1;
         de          <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            a[i] <= DEF[i];
            s[i] <= DEF[i];
         end
      end else begin
         if (en) begin
            pix_x       <= hc;
            pix_y       <= vc;
            blank       <= hb | vb;
            de          <= ~(hb | vb);
            hsync       <= hs;
            vsync       <= vs;
            line_start  <= hc == '0;
            frame_start <= (hc == '0) && (vc == '0);
            hc          <= hw ? '0 : hn[C-1:0];
            if (hw)
               vc <= vw ? '0 : vn[C-1:0];
         end
         // apply copies the pre-write shadow; a same-cycle write lands in the shadow only
         if (ap)
            for (int i = 0; i < 8; i++)
               a[i] <= s[i];
         if (cfg_we)
            s[cfg_addr] <= cfg_data;
         cfg_pending <= ap ? cfg_commit : (cfg_pending | cfg_commit);
      end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences a horizontal and a vertical pixel counter to produce the video raster: pixel position, blank, data-enable, hsync, vsync and frame/line start strobes.
- All eight timing thresholds are programmable through a small config write port.
- Writes go to shadow registers and take effect only at a frame boundary, so a running display never sees a torn frame.
- Sits between the pixel clock domain's config master and the video output/pixel fetch logic.

Parameters:
- C, 10, counter and threshold width in bits.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  pixel clock enable; when low, all state and outputs hold.
- cfg_we  in  1  write strobe for shadow register cfg_addr.
- cfg_addr  in  3  0 h_blank_start, 1 h_sync_start, 2 h_sync_end, 3 h_total, 4 v_blank_start, 5 v_sync_start, 6 v_sync_end, 7 v_total.
- cfg_data  in  C  write data.
- cfg_commit  in  1  request that the shadow set become active at the next frame boundary.
- cfg_pending  out  1  commit requested but not yet applied.
- pix_x  out  C  horizontal position of the current output pixel.
- pix_y  out  C  vertical position of the current output pixel.
- blank  out  1  high outside the active area.
- de  out  1  equal to ~blank.
- hsync  out  1  high during the horizontal sync window.
- vsync  out  1  high during the vertical sync window.
- line_start  out  1  one-cycle pulse at pix_x==0.
- frame_start  out  1  one-cycle pulse at pix_x==0 && pix_y==0.

Behaviour:
- Internal state:
  - counters hc, vc;
  - active register set A and shadow set S (8 x C each);
  - pending flag.
- Reset:
  - hc = vc = 0, pending = 0.
  - A = S = 640x480 defaults: 640, 656, 752, 800, 480, 490, 492, 525.
  - Outputs: pix_x = pix_y = 0, blank = 1, de = 0, hsync = vsync = line_start = frame_start = 0, cfg_pending = 0.
- Per cycle with en=1, outputs register a decode of (hc, vc) using A, then the counters advance. Outputs therefore lag the counters by one cycle and are mutually aligned.
- Decode:
  - hblank = hc >= h_blank_start; vblank = vc >= v_blank_start; blank = hblank | vblank.
  - hsync = (hc >= h_sync_start) && (hc < h_sync_end); vsync uses the same rule on vc. An empty window (start >= end) gives a sync that is never asserted.
  - pix_x = hc, pix_y = vc. line_start = (hc==0); frame_start = (hc==0 && vc==0).
- Advance:
  - Wrap test is (hc+1) >= h_total, evaluated at C+1 bits. On wrap, hc becomes 0, else hc increments.
  - On h-wrap, vc follows the same rule against v_total; otherwise vc holds.
  - h_total or v_total of 0 or 1 wraps every cycle.
- Frame end = h-wrap && v-wrap in an en=1 cycle.
- Config:
  - cfg_we writes S[cfg_addr] regardless of en; A is never written directly.
  - cfg_commit (regardless of en) sets pending on the next clock. Commit while already pending has no further effect.
  - At frame end with pending=1: A <= S, pending <= 0, hc = vc = 0.
  - cfg_we in the same cycle as the apply: A takes the old S value; the new write lands in S only.
  - cfg_commit in the same cycle as an apply: pending stays 1, so the new S applies at the following frame end.
  - cfg_pending = pending.
- en=0: counters, A, outputs and pulses all hold. Pulse outputs remain at their last value, so downstream logic must qualify them with en.
- Async reset mid-frame: everything returns immediately to the reset values above. Any uncommitted S contents are lost and S reloads defaults.
- First en=1 cycle after reset: outputs show (0,0), with frame_start = line_start = 1, blank = 0, de = 1.

Test Plan:
- Reset, then 1 en cycle -> pix_x=0, pix_y=0, frame_start=1, line_start=1, de=1, hsync=0, vsync=0, cfg_pending=0.
- Defaults, run 800 cycles -> blank rises at pix_x=640; hsync high for pix_x 656..751 (96 cycles); next line_start 800 cycles after the first, with pix_y=1.
- Defaults, run a full frame of 420000 cycles -> vsync high only on lines 490 and 491; blank high on lines 480..524; frame_start recurs at cycle 420000.
- Write S = {4, 5, 6, 8, 2, 3, 4, 5} and commit mid-frame -> cfg_pending=1 until the default frame ends, then 0.
  - New frame is 40 cycles long: hsync at pix_x 5, blank for pix_x 4..7 and lines 2..4, vsync on line 3.
- Small config, toggle en low for 7 cycles mid-line -> all outputs frozen; the sequence resumes exactly where it stopped, and the frame length in en cycles is still 40.
- Small config, assert rst asynchronously mid-clock at pix_y=3 -> outputs return to reset values immediately and A returns to 640x480 defaults (next line_start 800 en cycles later).
